// File: rtl/rr_arbiter_if.sv
// Purpose: request/grant bundle between N requesters and the round-robin arbiter.
// Latency: none; wires only.
// Backpressure: none; requesters hold req high until they are finished with the resource.
interface rr_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           any_req;
`ifdef ARB_TIMEOUT_EN
  logic           expired;
`endif

`ifdef ARB_TIMEOUT_EN
  modport master (output req, input grant, grant_id, busy, any_req, expired);
  modport slave  (input req, output grant, grant_id, busy, any_req, expired);
`else
  modport master (output req, input grant, grant_id, busy, any_req);
  modport slave  (input req, output grant, grant_id, busy, any_req);
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter granting one of N requesters; the grant is held until release.
// Latency: a req sampled at edge k gives a grant after edge k; at least one idle cycle between grants.
// Backpressure: losers are not latched and must keep req high; ARB_TIMEOUT_EN adds a HOLD_MAX-cycle forced release.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  rr_arbiter_if.slave arb
);
  localparam int IDW = $clog2(N);

  // Reject parameter values the arbiter cannot support.
  if (N < 2) begin : g_bad_n
    $error("rr_arbiter: N must be >= 2");
  end
  if (HOLD_MAX < 2) begin : g_bad_hold
    $error("rr_arbiter: HOLD_MAX must be >= 2");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           busy_q, busy_d;

  // Scan results: the first requester at or after ptr, wrapping around.
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] cand;
  logic           timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exp_q, exp_d;
`endif

  // The wake-up hint must work even while the arbiter is held in reset.
  assign arb.any_req  = |arb.req;
  assign arb.grant    = grant_q;
  assign arb.grant_id = id_q;
  assign arb.busy     = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign arb.expired  = exp_q;
`endif

  // State and output registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      exp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
`endif
    end
  end

  // Next-state logic: pick a winner in IDLE; hold the grant or release it in GRANT.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    found       = 1'b0;
    pick        = '0;
    cand        = '0;
    timeout_hit = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    exp_d       = 1'b0;
`endif

    // Walk the requesters from ptr upward; the first one set wins.
    for (int i = 0; i < N; i++) begin
      cand = IDW'((int'(ptr_q) + i) % N);
      if (!found && arb.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

`ifdef ARB_TIMEOUT_EN
    timeout_hit = (cnt_q == CW'(HOLD_MAX - 1));
`endif

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
          id_d    = pick;
          busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!arb.req[id_q] || timeout_hit) begin
          // Release: move the pointer past the holder so the others go first.
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
          exp_d   = timeout_hit & arb.req[id_q];
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_rr_arbiter.sv
// Purpose: scoreboard bench for rr_arbiter: directed scenarios followed by random request traffic.
// Latency: the expectation for each edge is queued at the preceding negedge and checked 1 time unit after the edge.
// Backpressure: none; the stimulus never waits on the DUT.
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int HM = 4;

  logic clk;
  logic rst_n;

  rr_arbiter_if #(.N(N)) bus ();

  rr_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [1:0]   id;
    logic         busy;
    logic         exp;
    logic         any;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: who holds the resource, whom to favour next, and how long the grant has lasted.
  int   m_holder = -1;
  int   m_next   = 0;
  int   m_cnt    = 0;
  int   m_id     = 0;
  bit   m_exp    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // Advance the model by one clock edge with inputs (rstn, r), then queue what the DUT should show.
  task automatic model_step(input bit rstn, input logic [N-1:0] r);
    exp_t e;
    bit   timed;
    bit   done;
    int   k;
    if (!rstn) begin
      m_holder = -1; m_next = 0; m_cnt = 0; m_id = 0; m_exp = 0;
    end else if (m_holder < 0) begin
      m_exp = 0;
      done  = 0;
      for (int i = 0; i < N; i++) begin
        k = (m_next + i) % N;
        if (!done && r[k]) begin
          done = 1; m_holder = k; m_id = k; m_cnt = 0;
        end
      end
    end else begin
      timed = 0;
`ifdef ARB_TIMEOUT_EN
      timed = (m_cnt == HM - 1);
`endif
      if (!r[m_holder] || timed) begin
        m_exp    = timed && r[m_holder];
        m_next   = (m_holder + 1) % N;
        m_holder = -1;
      end else begin
        m_cnt++;
        m_exp = 0;
      end
    end
    e.grant = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
    e.id    = 2'(m_id);
    e.busy  = (m_holder >= 0);
    e.exp   = m_exp;
    e.any   = |r;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus on the falling edge and queue the expectation for the next rising edge.
  task automatic cyc(input bit rstn, input logic [N-1:0] r);
    @(negedge clk);
    rst_n   = rstn;
    bus.req = r;
    model_step(rstn, r);
  endtask

  // Monitor: after every rising edge, pop the oldest expectation and compare it with the DUT outputs.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant",    32'(bus.grant),    32'(e.grant));
      check("grant_id", 32'(bus.grant_id), 32'(e.id));
      check("busy",     32'(bus.busy),     32'(e.busy));
      check("any_req",  32'(bus.any_req),  32'(e.any));
`ifdef ARB_TIMEOUT_EN
      check("expired",  32'(bus.expired),  32'(e.exp));
`endif
    end
  end

  logic [N-1:0] r;

  initial begin
    rst_n   = 1'b0;
    bus.req = '0;

    // Reset held with every requester asserting.
    cyc(0, 4'b1111); cyc(0, 4'b1111);

    // Single requester: grant, hold, then release.
    cyc(1, 4'b0100); cyc(1, 4'b0100); cyc(1, 4'b0000); cyc(1, 4'b0000);

    // Wrap-around: requester 3 is served before requester 0.
    cyc(1, 4'b0100); cyc(1, 4'b0100);
    repeat (3) cyc(1, 4'b1001);
    repeat (2) cyc(1, 4'b0001);
    repeat (2) cyc(1, 4'b0000);

    // Rotation: all request; each holder drops after two granted cycles, then re-asserts.
    cyc(0, 4'b0000);
    repeat (24) begin
      r = 4'b1111;
      if (m_holder >= 0 && m_cnt + 1 >= 2) r[m_holder] = 1'b0;
      cyc(1, r);
    end

    // Reset in the middle of a grant brings the pointer back to 0.
    cyc(0, 4'b0000);
    repeat (3) cyc(1, 4'b0010);
    cyc(0, 4'b0010);
    repeat (3) cyc(1, 4'b0011);
    repeat (2) cyc(1, 4'b0000);

    // Long-held requests: forced release when the timeout is built in.
    repeat (14) cyc(1, 4'b0011);
    repeat (2) cyc(1, 4'b0000);

    // Random traffic with occasional resets.
    r = '0;
    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
      cyc(($urandom_range(0, 149) != 0), r);
    end

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
